// File: rtl/nibbler_pkg.sv
// rtl/nibbler_pkg.sv - shared opcodes, FSM states and field slices for the NibblER CPU
package nibbler_pkg;

  localparam logic [2:0] ALU_OUT = 3'b000;
  localparam logic [2:0] ALU_CMP = 3'b001;
  localparam logic [2:0] ALU_LD  = 3'b010;
  localparam logic [2:0] ALU_ADD = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_OUT  = 4'h1;
  localparam logic [3:0] OP_ST   = 4'h2;
  localparam logic [3:0] OP_CMPI = 4'h3;
  localparam logic [3:0] OP_CMPM = 4'h4;
  localparam logic [3:0] OP_LIT  = 4'h5;
  localparam logic [3:0] OP_IN   = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_ADDM = 4'h9;
  localparam logic [3:0] OP_NORI = 4'hA;
  localparam logic [3:0] OP_NORM = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JC   = 4'hD;
  localparam logic [3:0] OP_JZ   = 4'hE;
  localparam logic [3:0] OP_JNZ  = 4'hF;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  localparam logic [1:0] BSEL_IMM = 2'd0;
  localparam logic [1:0] BSEL_RAM = 2'd1;
  localparam logic [1:0] BSEL_IN  = 2'd2;

  // Jump condition codes equal the low two opcode bits of JMP/JC/JZ/JNZ
  localparam logic [1:0] JC_ALWAYS = 2'd0;
  localparam logic [1:0] JC_CARRY  = 2'd1;
  localparam logic [1:0] JC_ZERO   = 2'd2;
  localparam logic [1:0] JC_NZERO  = 2'd3;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEMWAIT,
    ST_EXEC
  } state_e;

  function automatic logic op_reads_mem(input logic [3:0] op);
    return (op == OP_CMPM) || (op == OP_LD) || (op == OP_ADDM) || (op == OP_NORM);
  endfunction

endpackage

// File: rtl/nibbler_idecode.sv
// rtl/nibbler_idecode.sv - combinational opcode decoder feeding the sequencer
module nibbler_idecode
  import nibbler_pkg::*;
(
  input  logic [3:0] op_i,
  output logic [2:0] alu_op_o,
  output logic [1:0] b_sel_o,
  output logic       acc_we_o,
  output logic       flag_we_o,
  output logic       is_mem_rd_o,
  output logic       is_jump_o,
  output logic [1:0] jcond_o,
  output logic       is_st_o,
  output logic       is_out_o,
  output logic       is_in_o
);

  always_comb begin
    alu_op_o    = ALU_OUT;
    is_mem_rd_o = op_reads_mem(op_i);
    b_sel_o     = is_mem_rd_o ? BSEL_RAM : BSEL_IMM;
    acc_we_o    = 1'b0;
    flag_we_o   = 1'b0;
    is_jump_o   = op_i[3] & op_i[2];
    jcond_o     = op_i[1:0];
    is_st_o     = (op_i == OP_ST);
    is_out_o    = (op_i == OP_OUT);
    is_in_o     = (op_i == OP_IN);
    case (op_i)
      OP_CMPI, OP_CMPM: begin
        alu_op_o  = ALU_CMP;
        flag_we_o = 1'b1;
      end
      OP_LIT, OP_LD: begin
        alu_op_o = ALU_LD;
        acc_we_o = 1'b1;
      end
      OP_IN: begin
        alu_op_o = ALU_LD;
        acc_we_o = 1'b1;
        b_sel_o  = BSEL_IN;
      end
      OP_ADDI, OP_ADDM: begin
        alu_op_o  = ALU_ADD;
        acc_we_o  = 1'b1;
        flag_we_o = 1'b1;
      end
      OP_NORI, OP_NORM: begin
        alu_op_o  = ALU_NOR;
        acc_we_o  = 1'b1;
        flag_we_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/nibbler_ctrl.sv
// rtl/nibbler_ctrl.sv - NibblER fetch/decode/execute sequencer driving ALU, RAM and I/O
module nibbler_ctrl
  import nibbler_pkg::*;
#(
  parameter int PW  = 12,
  parameter int DAW = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic [PW-1:0]  rom_addr,
  input  logic [15:0]    rom_data,
  output logic [DAW-1:0] ram_addr,
  output logic [3:0]     ram_wdata,
  output logic           ram_we,
  input  logic [3:0]     ram_rdata,
  output logic [2:0]     alu_op,
  output logic [3:0]     alu_a,
  output logic [3:0]     alu_b,
  input  logic [3:0]     alu_out,
  input  logic           alu_carry,
  input  logic           alu_zero,
  input  logic           in_valid,
  input  logic [3:0]     in_data,
  output logic           in_ready,
  output logic           out_valid,
  output logic [3:0]     out_data
);

  state_e        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;
  logic [3:0]    acc_q, acc_d;
  logic          carry_q, carry_d;
  logic          zero_q, zero_d;
  logic          out_valid_q, out_valid_d;
  logic [3:0]    out_data_q, out_data_d;

  logic [1:0] b_sel, jcond;
  logic       acc_we, flag_we, is_mem_rd, is_jump, is_st, is_out, is_in;
  logic       jump_taken;

  nibbler_idecode u_idecode (
    .op_i        (ir_q[OP_MSB:OP_LSB]),
    .alu_op_o    (alu_op),
    .b_sel_o     (b_sel),
    .acc_we_o    (acc_we),
    .flag_we_o   (flag_we),
    .is_mem_rd_o (is_mem_rd),
    .is_jump_o   (is_jump),
    .jcond_o     (jcond),
    .is_st_o     (is_st),
    .is_out_o    (is_out),
    .is_in_o     (is_in)
  );

  assign rom_addr  = pc_q;
  assign ram_addr  = ir_q[DAW-1:0];
  assign ram_wdata = acc_q;
  assign alu_a     = acc_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    case (b_sel)
      BSEL_RAM: alu_b = ram_rdata;
      BSEL_IN:  alu_b = in_data;
      default:  alu_b = ir_q[IMM_MSB:IMM_LSB];
    endcase
  end

  always_comb begin
    case (jcond)
      JC_ALWAYS: jump_taken = 1'b1;
      JC_CARRY:  jump_taken = carry_q;
      JC_ZERO:   jump_taken = zero_q;
      default:   jump_taken = ~zero_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    ram_we      = 1'b0;
    in_ready    = 1'b0;
    case (state_q)
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        ir_d    = rom_data;
        pc_d    = pc_q + PW'(1);
        state_d = op_reads_mem(rom_data[OP_MSB:OP_LSB]) ? ST_MEMWAIT : ST_EXEC;
      end
      ST_MEMWAIT: state_d = ST_EXEC;
      default: begin
        state_d  = ST_FETCH;
        in_ready = is_in;
        ram_we   = is_st;
        // IN parks here and commits nothing until the port presents data
        if (is_in && !in_valid) begin
          state_d = ST_EXEC;
        end else begin
          if (acc_we) acc_d = alu_out;
          if (flag_we) begin
            carry_d = alu_carry;
            zero_d  = alu_zero;
          end
          if (is_out) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_q;
          end
          if (is_jump && jump_taken) pc_d = ir_q[PW-1:0];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // is_mem_rd is carried for the ALU-side interface; state sequencing uses the package helper
  logic unused_ok;
  assign unused_ok = is_mem_rd;

endmodule

// File: tb/tb_nibbler_ctrl.sv
// tb/tb_nibbler_ctrl.sv - randomized and directed bench for nibbler_ctrl against an ISA-level model
module tb_nibbler_ctrl;

  localparam int MAXC = 1000;

  logic        clk, rst_n;
  logic [11:0] rom_addr, ram_addr;
  logic [15:0] rom_data;
  logic [3:0]  ram_wdata, ram_rdata, alu_a, alu_b, alu_out, in_data, out_data;
  logic        ram_we, alu_carry, alu_zero, in_valid, in_ready, out_valid;
  logic [2:0]  alu_op;
  logic [4:0]  alu_t;

  logic [3:0]  rom_addr4, ram_addr4, ram_wdata4, alu_a4, alu_b4, out_data4;
  logic [15:0] rom_data4;
  logic        ram_we4, in_ready4, out_valid4;
  logic [2:0]  alu_op4;

  logic [15:0] rom  [4096];
  logic [3:0]  ram  [4096];
  logic [15:0] rom4 [16];

  bit          iv_a    [MAXC];
  logic [3:0]  id_a    [MAXC];
  logic [11:0] e_rom   [MAXC];
  bit          e_we    [MAXC];
  logic [11:0] e_waddr [MAXC];
  logic [3:0]  e_wdata [MAXC];
  bit          e_ov    [MAXC];
  logic [3:0]  e_od    [MAXC];
  bit          e_ir    [MAXC];
  logic [3:0]  mram [int];

  int n_pass = 0;
  int n_chk  = 0;

  nibbler_ctrl #(.PW(12), .DAW(12)) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data)
  );

  nibbler_ctrl #(.PW(4), .DAW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr4), .rom_data(rom_data4),
    .ram_addr(ram_addr4), .ram_wdata(ram_wdata4), .ram_we(ram_we4), .ram_rdata(4'h0),
    .alu_op(alu_op4), .alu_a(alu_a4), .alu_b(alu_b4), .alu_out(4'h0),
    .alu_carry(1'b0), .alu_zero(1'b0), .in_valid(1'b0), .in_data(4'h0),
    .in_ready(in_ready4), .out_valid(out_valid4), .out_data(out_data4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data  <= rom[rom_addr];
    rom_data4 <= rom4[rom_addr4];
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  // Reference ALU: CMP carry is the borrow of a-b, zero always reflects the result
  always_comb begin
    alu_t     = 5'd0;
    alu_out   = alu_a;
    alu_carry = 1'b0;
    case (alu_op)
      3'b001: begin alu_t = {1'b0, alu_a} - {1'b0, alu_b}; alu_out = alu_t[3:0]; alu_carry = alu_t[4]; end
      3'b010: alu_out = alu_b;
      3'b011: begin alu_t = {1'b0, alu_a} + {1'b0, alu_b}; alu_out = alu_t[3:0]; alu_carry = alu_t[4]; end
      3'b100: alu_out = ~(alu_a | alu_b);
      default: ;
    endcase
    alu_zero = (alu_out == 4'h0);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Instruction-level model: runs the program and lays each instruction's cycles on a timeline
  task automatic build_trace(input int n);
    logic [11:0] pc, f;
    logic [3:0]  acc, od, b, op;
    logic [15:0] ins;
    bit          c, z, pend, taken;
    int          cyc, lat, k;
    pc = 0; acc = 0; od = 0; c = 0; z = 0; pend = 0; cyc = 0;
    mram.delete();
    while (cyc < n) begin
      ins = rom[pc];
      op  = ins[15:12];
      f   = ins[11:0];
      lat = (op inside {4'h4, 4'h7, 4'h9, 4'hB}) ? 4 : 3;
      b   = (op inside {4'h4, 4'h7, 4'h9, 4'hB}) ? (mram.exists(int'(f)) ? mram[int'(f)] : 4'h0) : f[3:0];
      if (op == 4'h6) begin
        k = cyc + 2;
        while (k < n && !iv_a[k]) k++;
        lat = k - cyc + 1;
        b   = (k < n) ? id_a[k] : 4'h0;
      end
      for (int j = 0; j < lat; j++) begin
        if (cyc + j < n) begin
          e_rom[cyc+j]   = (j < 2) ? pc : pc + 12'd1;
          e_ov[cyc+j]    = pend && (j == 0);
          e_od[cyc+j]    = od;
          e_we[cyc+j]    = (op == 4'h2) && (j == lat - 1);
          e_waddr[cyc+j] = f;
          e_wdata[cyc+j] = acc;
          e_ir[cyc+j]    = (op == 4'h6) && (j >= 2);
        end
      end
      pend = 0;
      cyc += lat;
      taken = 0;
      case (op)
        4'h1: begin od = acc; pend = 1; end
        4'h2: mram[int'(f)] = acc;
        4'h3, 4'h4: begin c = (acc < b); z = (acc == b); end
        4'h5, 4'h6, 4'h7: acc = b;
        4'h8, 4'h9: begin {c, acc} = {1'b0, acc} + {1'b0, b}; z = (acc == 0); end
        4'hA, 4'hB: begin acc = ~(acc | b); c = 0; z = (acc == 0); end
        4'hC: taken = 1;
        4'hD: taken = c;
        4'hE: taken = z;
        4'hF: taken = !z;
        default: ;
      endcase
      pc = taken ? f : pc + 12'd1;
    end
  endtask

  task automatic run_test(input int n, input int mode4);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    build_trace(n);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < n; cyc++) begin
      in_valid = iv_a[cyc];
      in_data  = id_a[cyc];
      #1;
      chk($sformatf("rom_addr@%0d", cyc), rom_addr, e_rom[cyc]);
      chk($sformatf("ram_we@%0d", cyc), ram_we, e_we[cyc]);
      if (e_we[cyc]) begin
        chk($sformatf("ram_addr@%0d", cyc), ram_addr, e_waddr[cyc]);
        chk($sformatf("ram_wdata@%0d", cyc), ram_wdata, e_wdata[cyc]);
      end
      chk($sformatf("out_valid@%0d", cyc), out_valid, e_ov[cyc]);
      chk($sformatf("out_data@%0d", cyc), out_data, e_od[cyc]);
      chk($sformatf("in_ready@%0d", cyc), in_ready, e_ir[cyc]);
      if (mode4 == 1 && cyc % 3 == 0 && cyc <= 48)
        chk($sformatf("pw4_wrap@%0d", cyc), rom_addr4, (cyc / 3) % 16);
      if (mode4 == 2 && cyc == 47) chk("pw4_jnz_incr_wrap", rom_addr4, 0);
      if (mode4 == 2 && cyc == 48) chk("pw4_jnz_target", rom_addr4, 4'hA);
      @(negedge clk);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 4096; i++) rom[i] = 16'h0000;
    for (int i = 0; i < MAXC; i++) begin
      iv_a[i] = 0;
      id_a[i] = 4'($urandom);
    end
  endtask

  task automatic gen_random_prog();
    logic [3:0]  op;
    logic [11:0] f;
    for (int a = 0; a < 8; a++) begin
      rom[2*a]   = {4'h5, 8'h00, 4'($urandom)};
      rom[2*a+1] = {4'h2, 12'(a)};
    end
    for (int i = 16; i < 4096; i++) begin
      op = 4'($urandom);
      f  = 12'($urandom);
      if (op inside {4'h2, 4'h4, 4'h7, 4'h9, 4'hB}) f = f & 12'h007;
      rom[i] = {op, f};
    end
    for (int i = 0; i < MAXC; i++) begin
      iv_a[i] = ($urandom_range(2) == 0);
      id_a[i] = 4'($urandom);
    end
  endtask

  function automatic int count_ov(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(e_ov[i]);
    return s;
  endfunction

  function automatic int count_we(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(e_we[i]);
    return s;
  endfunction

  function automatic int count_ir(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(e_ir[i]);
    return s;
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 4'h0;
    for (int i = 0; i < 16; i++) rom4[i] = 16'h0000;
    clear_prog();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rom_addr", rom_addr, 0);
    chk("reset_ram_we", ram_we, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_data", out_data, 0);

    // LIT 5; OUT; loop
    clear_prog();
    rom[0] = 16'h5005; rom[1] = 16'h1000; rom[2] = 16'hC002;
    run_test(60, 1);
    chk("pin_t1_rom0", e_rom[0], 0);
    chk("pin_t1_rom3", e_rom[3], 1);
    chk("pin_t1_rom6", e_rom[6], 2);
    chk("pin_t1_ov6", e_ov[6], 1);
    chk("pin_t1_od6", e_od[6], 5);
    chk("pin_t1_ov_count", count_ov(60), 1);

    // LIT 9; ADDI 8 (carry); OUT; JC; ADDI F (zero); OUT; JZ
    clear_prog();
    rom[0] = 16'h5009; rom[1] = 16'h8008; rom[2] = 16'h1000; rom[3] = 16'hD006;
    rom[4] = 16'h1000; rom[5] = 16'hC005; rom[6] = 16'h800F; rom[7] = 16'h1000;
    rom[8] = 16'hE00A; rom[9] = 16'hC009; rom[10] = 16'hC00A;
    rom4[15] = 16'hF03A;
    run_test(60, 2);
    chk("pin_t2_od9", e_od[9], 1);
    chk("pin_t2_jc_taken", e_rom[12], 6);
    chk("pin_t2_od18", e_od[18], 0);
    chk("pin_t2_jz_taken", e_rom[21], 10);

    // LIT 3; CMPI 4; JC 0x020 -> borrow, taken
    clear_prog();
    rom[0] = 16'h5003; rom[1] = 16'h3004; rom[2] = 16'hD020; rom[3] = 16'h1000;
    rom[4] = 16'hC004; rom[32] = 16'h1000; rom[33] = 16'hC021;
    run_test(30, 0);
    chk("pin_t3_taken_pc", e_rom[9], 12'h020);
    chk("pin_t3_acc_kept", e_od[12], 3);
    rom[1] = 16'h3002;
    run_test(30, 0);
    chk("pin_t3_not_taken_pc", e_rom[9], 3);

    // LIT 7; ST 5; LIT 0; JZ (not taken); LD 5; OUT
    clear_prog();
    rom[0] = 16'h5007; rom[1] = 16'h2005; rom[2] = 16'h5000; rom[3] = 16'hE010;
    rom[4] = 16'h7005; rom[5] = 16'h1000; rom[6] = 16'hC006; rom[16] = 16'hC010;
    run_test(30, 0);
    chk("pin_t4_we5", e_we[5], 1);
    chk("pin_t4_waddr", e_waddr[5], 5);
    chk("pin_t4_wdata", e_wdata[5], 7);
    chk("pin_t4_we_count", count_we(30), 1);
    chk("pin_t4_jz_not_taken", e_rom[12], 4);
    chk("pin_t4_ld_acc", e_od[19], 7);

    // IN with five idle cycles, then data A
    clear_prog();
    rom[0] = 16'h6000; rom[1] = 16'h1000; rom[2] = 16'hC002;
    iv_a[7] = 1; id_a[7] = 4'hA;
    run_test(20, 0);
    chk("pin_in_ready_cycles", count_ir(20), 6);
    chk("pin_in_ov11", e_ov[11], 1);
    chk("pin_in_od11", e_od[11], 4'hA);

    // Reset asserted while IN is waiting
    clear_prog();
    rom[0] = 16'h5006; rom[1] = 16'h1000; rom[2] = 16'h6000; rom[3] = 16'hC003;
    run_test(12, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_rom_addr", rom_addr, 0);
    chk("midreset_in_ready", in_ready, 0);
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_out_data", out_data, 0);
    chk("midreset_ram_we", ram_we, 0);

    for (int r = 0; r < 3; r++) begin
      gen_random_prog();
      run_test(900, 0);
    end

    rst_n = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/nibbler_ctrl.md
Name: nibbler_ctrl

Overview:
Control/sequencer unit for the 4-bit NibblER CPU: the issuing end of the ALU interface.
- Fetches 16-bit instructions from program ROM and decodes them.
- Drives ALU opcode and operands, then captures ALU result, carry and zero into the accumulator and flag registers.
- Sequences data-RAM reads/writes, the IN/OUT ports and conditional jumps.

Parameters:
PW, 12, program-counter width (1..12); jump targets use ir[PW-1:0].
DAW, 12, data-RAM address width (1..12); address = ir[DAW-1:0].

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rom_addr  out  PW  program ROM address (registered PC)
rom_data  in  16  ROM read data, valid one cycle after rom_addr
ram_addr  out  DAW  data RAM address, = ir[DAW-1:0]
ram_wdata  out  4  RAM write data (= acc)
ram_we  out  1  RAM write strobe
ram_rdata  in  4  RAM read data, valid one cycle after ram_addr
alu_op  out  3  ALU opcode: OUT=000 CMP=001 LD=010 ADD=011 NOR=100
alu_a  out  4  ALU A operand (= acc)
alu_b  out  4  ALU B operand (imm / ram_rdata / in_data)
alu_out  in  4  ALU result
alu_carry  in  1  ALU carry (borrow for CMP)
alu_zero  in  1  ALU zero
in_valid  in  1  input-port data valid
in_data  in  4  input-port data
in_ready  out  1  controller waiting on IN
out_valid  out  1  one-cycle output strobe
out_data  out  4  registered output value

Behaviour:
- Instruction word: [15:12] op, [11:0] addr/imm; imm = [3:0].
- Ops:
  - 0 NOP, 1 OUT, 2 ST, 3 CMPI, 4 CMPM, 5 LIT, 6 IN, 7 LD.
  - 8 ADDI, 9 ADDM, A NORI, B NORM.
  - C JMP, D JC, E JZ, F JNZ.
- ALU opcode mapping:
  - OUT/ST/NOP/jumps -> OUT.
  - CMPI/CMPM -> CMP.
  - LIT/IN/LD -> LD.
  - ADDx -> ADD.
  - NORx -> NOR.
- alu_b source: M-forms use ram_rdata, IN uses in_data, all others use imm.
- FSM states: FETCH, DECODE, MEMWAIT, EXEC.
  - FETCH: rom_addr=pc. Next state DECODE.
  - DECODE: ir<=rom_data; pc<=pc+1 (wraps 2^PW-1 -> 0). Next state MEMWAIT if op in {4,7,9,B}, else EXEC.
  - MEMWAIT: ram_addr stable, one cycle. Next state EXEC.
  - EXEC: perform the op. Next state FETCH, except IN, which holds in EXEC until it completes.
- Latency: 3 cycles per non-memory instruction, 4 per memory-read instruction; IN adds its wait cycles.
- Accumulator writes (from alu_out, EXEC only): LIT, IN, LD, ADDx, NORx. CMP leaves acc unchanged.
- Flag writes (carry<=alu_carry, zero<=alu_zero, EXEC only): CMPx, ADDx, NORx. All other ops leave flags unchanged.
- ST: ram_we=1 for exactly the EXEC cycle; ram_wdata=acc.
- OUT: out_data<=acc and out_valid=1 for exactly one cycle, following EXEC.
- IN:
  - in_ready=1 throughout EXEC.
  - Completes in the first EXEC cycle with in_valid=1, including an in_valid that was already high on entry.
  - No timeout.
- Jumps, in EXEC:
  - Taken condition: JMP always; JC if carry=1; JZ if zero=1; JNZ if zero=0.
  - Taken: pc<=ir[PW-1:0]. Not taken: pc keeps the incremented value.
  - A jump to its own address loops forever.
- 4-bit arithmetic wraps; carry comes solely from the ALU.
- Reset (async assert, deasserts synchronously to clk):
  - pc=0, ir=0, acc=0, carry=0, zero=0, state=FETCH.
  - ram_we=0, out_valid=0, in_ready=0, out_data=0.
  - Reset during an IN wait or a memory wait abandons the instruction with no side effects.

Decomposition:
- nibbler_pkg holds:
  - ALU opcode constants (shared with the ALU).
  - 4-bit instruction opcode constants.
  - FSM state enum.
  - Instruction field slice constants.
- One combinational sub-module, nibbler_idecode, maps op to: alu_op, b_sel, acc_we, flag_we, is_mem_rd, is_jump and the jump condition.

Test Plan:
- Reset, then ROM {LIT 5; OUT} -> out_valid pulses once with out_data=5; rom_addr sequence 0,1,2; 3 cycles per instruction.
- LIT 9; ADDI 8 -> acc=1, carry=1, zero=0. Then ADDI F -> acc=0, carry=1, zero=1.
- LIT 3; CMPI 4; JC 0x020 -> borrow sets carry=1, pc=0x020, acc stays 3. Repeat with CMPI 2 -> not taken, pc=3.
- LIT 7; ST 0x005; LIT 0; LD 0x005:
  - ram_we high exactly one cycle with addr 5, data 7.
  - LD takes 4 cycles; acc=7; flags unchanged.
- IN with in_valid held low 5 cycles, then in_data=A -> in_ready high 6 cycles, acc=A. Reset asserted mid-wait -> all outputs return to reset values and pc=0.
- PW=4: 16 NOPs -> pc wraps 15 -> 0. JNZ with zero=0 at address 15 jumps to its target correctly.
